// File: rtl/mcdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcdp_pkg
// Description : Opcodes, FSM states and instruction field positions shared
//               by the multi-cycle datapath and its register file.
// Revision    : 1.0 - initial release
// ============================================================================

package mcdp_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int OPC_LSB = 28;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 23;
  localparam int RS1_LSB = 18;
  localparam int RS2_LSB = 13;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 12;

endpackage

`default_nettype wire

// File: rtl/mcdp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mcdp_regfile
// Description : Two asynchronous read ports, one synchronous write port;
//               entry 0 always reads as zero and ignores writes.
// Revision    : 1.0 - initial release
// ============================================================================

module mcdp_regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  localparam int IDX_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_datapath
// Description : Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequencing with a
//               req/ack data-memory port. Optional MCDP_ILLEGAL_TRAP_EN makes
//               opcodes B-E halt with trap instead of acting as NOPs.
// Revision    : 1.0 - initial release
// ============================================================================

module multicycle_datapath
  import mcdp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int IMEM_AW   = 8,
  parameter int DMEM_AW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [DATA_W-1:0]  PC_next,
  output logic [DATA_W-1:0]  finalout,
  output logic               retire,
  output logic               halted,
  output logic               trap
);

  localparam int IDX_W = $clog2(REG_COUNT);

  state_t state, next_state;

  logic [DATA_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_out, mdr;

  logic [OPC_W-1:0]  opcode;
  logic [IDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
  logic [IMM_W-1:0]  imm12;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic [DATA_W-1:0] alu_res, wb_data;
  logic [DATA_W-1:0] pc_plus4, pc_target, pc_d;
  logic              pc_we;
  logic              unused_ir;

  assign opcode   = ir[OPC_LSB +: OPC_W];
  assign rd_idx   = ir[RD_LSB  +: IDX_W];
  assign rs1_idx  = ir[RS1_LSB +: IDX_W];
  assign rs2_idx  = ir[RS2_LSB +: IDX_W];
  assign imm12    = ir[IMM_LSB +: IMM_W];
  assign imm_sext = {{(DATA_W-IMM_W){imm12[IMM_W-1]}}, imm12};
  // Bit 12 and any register-index bits above IDX_W carry no meaning.
  assign unused_ir = ^ir;

  assign pc_plus4  = pc + DATA_W'(4);
  assign pc_target = pc + imm_q;
  assign wb_data   = (opcode == OP_LW) ? mdr : alu_out;

  mcdp_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs1_idx),
    .ra_data (rs1_val),
    .rb_addr (rs2_idx),
    .rb_data (rs2_val),
    .wr_en   (state == S_WB),
    .wr_addr (rd_idx),
    .wr_data (wb_data)
  );

  // Loads and stores share the ADDI address computation.
  always_comb begin
    alu_res = a_q + imm_q;
    case (opcode)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = a_q + imm_q;
    endcase
  end

`ifdef MCDP_ILLEGAL_TRAP_EN
  logic trap_set;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_d       = pc_plus4;
`ifdef MCDP_ILLEGAL_TRAP_EN
    trap_set   = 1'b0;
`endif
    case (state)
      S_IDLE:   if (run) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: next_state = S_WB;
          OP_LW, OP_SW: next_state = S_MEM;
          OP_BEQ, OP_BNE, OP_JMP: begin
            next_state = S_FETCH;
            retire     = 1'b1;
            pc_we      = 1'b1;
            if ((opcode == OP_JMP) ||
                ((opcode == OP_BEQ) && (a_q == b_q)) ||
                ((opcode == OP_BNE) && (a_q != b_q))) begin
              pc_d = pc_target;
            end
          end
          OP_HALT: begin
            next_state = S_HALT;
            retire     = 1'b1;
          end
          default: begin
`ifdef MCDP_ILLEGAL_TRAP_EN
            next_state = S_HALT;
            trap_set   = 1'b1;
`else
            next_state = S_FETCH;
            retire     = 1'b1;
            pc_we      = 1'b1;
`endif
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == OP_LW) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
            pc_we      = 1'b1;
          end
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
        pc_we      = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      finalout <= '0;
    end else begin
      if (pc_we) pc <= pc_d;
      case (state)
        S_FETCH: ir <= imem_data;
        S_DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          imm_q <= imm_sext;
        end
        S_EXEC: alu_out <= alu_res;
        S_MEM:  if (dmem_ack && (opcode == OP_LW)) mdr <= dmem_rdata;
        S_WB:   finalout <= wb_data;
        default: ;
      endcase
    end
  end

`ifdef MCDP_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      trap <= 1'b0;
    end else if (trap_set) begin
      trap <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

  // Request is a pure state decode so a reset drops it on the same edge.
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = dmem_req && (opcode == OP_SW);
  assign dmem_addr  = alu_out[DMEM_AW-1:0];
  assign dmem_wdata = b_q;
  assign imem_addr  = pc[IMEM_AW-1:0];
  assign PC_next    = pc;
  assign halted     = (state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_datapath
// Description : Directed programs checked cycle-by-cycle against an ISA-level
//               latency model, plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] PC_next, finalout;
  logic        retire, halted, trap;

  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_wait = 0;
  int          wcnt = 0;

  logic [31:0] imem_arr [256];
  logic [31:0] ram [256];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  assign imem_data  = imem_arr[imem_addr];
  assign dmem_rdata = ram[dmem_addr];
  assign dmem_ack   = resp_ack | stray_ack;

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .PC_next    (PC_next),
    .finalout   (finalout),
    .retire     (retire),
    .halted     (halted),
    .trap       (trap)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [4:0] f_rd, f_rs1, f_rs2;
    logic [11:0] f_imm;
    f_rd = rd[4:0]; f_rs1 = rs1[4:0]; f_rs2 = rs2[4:0]; f_imm = imm[11:0];
    return {op, f_rd, f_rs1, f_rs2, 1'b0, f_imm};
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] w);
    return {{20{w[11]}}, w[11:0]};
  endfunction

  // ---------------- ISA-level model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [256];
  logic [31:0] m_pc, m_fin, m_ir;
  bit          m_run, m_halt, m_trap, m_acked;
  int          m_cyc, m_ack_cyc;

  function automatic bit is_mem(input logic [3:0] op);
    return (op == 4'h6) || (op == 4'h7);
  endfunction

  function automatic bit m_exp_req();
    return m_run && (m_cyc >= 3) && is_mem(m_ir[31:28]) && !m_acked;
  endfunction

  // Retire cycle index within the instruction: 3-cycle and 4-cycle classes,
  // and memory ops that finish on (SW) or one cycle after (LW) the ack.
  function automatic bit m_retire_now();
    logic [3:0] op;
    op = m_ir[31:28];
    if (!m_run || m_cyc < 2) return 1'b0;
    if (op <= 4'h5) return m_cyc == 3;
    if (op == 4'h7) return m_exp_req() && dmem_ack;
    if (op == 4'h6) return m_acked && (m_cyc == m_ack_cyc + 1);
    if (op >= 4'h8 && op <= 4'hA) return m_cyc == 2;
    if (op == 4'hF) return m_cyc == 2;
`ifdef MCDP_ILLEGAL_TRAP_EN
    return 1'b0;
`else
    return m_cyc == 2;
`endif
  endfunction

  function automatic logic [31:0] m_addr();
    int rs1;
    rs1 = m_ir[22:18];
    return m_regs[rs1] + sx(m_ir);
  endfunction

  task automatic m_wb(input int rd, input logic [31:0] v);
    if (rd != 0) m_regs[rd] = v;
    m_fin = v;
    m_pc  = m_pc + 32'd4;
  endtask

  task automatic m_exec();
    logic [3:0] op;
    int rd, rs1, rs2;
    logic [31:0] a, b, im, ad;
    op = m_ir[31:28]; rd = m_ir[27:23]; rs1 = m_ir[22:18]; rs2 = m_ir[17:13];
    a = m_regs[rs1]; b = m_regs[rs2]; im = sx(m_ir); ad = a + im;
    case (op)
      4'h0: m_wb(rd, a + b);
      4'h1: m_wb(rd, a - b);
      4'h2: m_wb(rd, a & b);
      4'h3: m_wb(rd, a | b);
      4'h4: m_wb(rd, a ^ b);
      4'h5: m_wb(rd, ad);
      4'h6: m_wb(rd, m_mem[ad[7:0]]);
      4'h7: begin m_mem[ad[7:0]] = b; m_pc = m_pc + 32'd4; end
      4'h8: m_pc = (a == b) ? m_pc + im : m_pc + 32'd4;
      4'h9: m_pc = (a != b) ? m_pc + im : m_pc + 32'd4;
      4'hA: m_pc = m_pc + im;
      4'hF: begin m_halt = 1'b1; m_run = 1'b0; end
      default: m_pc = m_pc + 32'd4;
    endcase
  endtask

  task automatic model_step();
    bit ret;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = '0; m_fin = '0; m_ir = '0;
      m_run = 1'b0; m_halt = 1'b0; m_trap = 1'b0; m_acked = 1'b0; m_cyc = 0;
      return;
    end
    if (!m_run) begin
      if (!m_halt && run) begin m_run = 1'b1; m_cyc = 0; m_acked = 1'b0; end
      return;
    end
    if (m_cyc == 0) m_ir = imem_arr[m_pc[7:0]];
    ret = m_retire_now();
    if (m_exp_req() && dmem_ack) begin m_acked = 1'b1; m_ack_cyc = m_cyc; end
`ifdef MCDP_ILLEGAL_TRAP_EN
    if (m_cyc == 2 && m_ir[31:28] >= 4'hB && m_ir[31:28] <= 4'hE) begin
      m_halt = 1'b1; m_trap = 1'b1; m_run = 1'b0;
      return;
    end
`endif
    if (ret) begin
      m_exec();
      m_cyc = 0; m_acked = 1'b0;
    end else begin
      m_cyc++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; m_mem[i] = '0; end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // RAM write side of the environment.
  initial forever begin
    @(posedge clk);
    if (dmem_req === 1'b1 && dmem_we === 1'b1 && dmem_ack) ram[dmem_addr] = dmem_wdata;
  end

  // Ack responder: ack after ack_wait cycles of held request.
  initial forever begin
    @(posedge clk); #1;
    resp_ack = 1'b0;
    if (dmem_req === 1'b1) begin
      if (wcnt >= ack_wait) begin resp_ack = 1'b1; wcnt = 0; end
      else wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("retire", {31'd0, retire}, {31'd0, m_retire_now()});
      chk("pc", PC_next, m_pc);
      chk("finalout", finalout, m_fin);
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("trap", {31'd0, trap}, {31'd0, m_trap});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, m_exp_req()});
      if (m_exp_req() && dmem_req === 1'b1) begin
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, (m_ir[31:28] == 4'h7)});
        chk("dmem_addr", {24'd0, dmem_addr}, {24'd0, m_addr() & 32'hFF});
        if (m_ir[31:28] == 4'h7)
          chk("dmem_wdata", dmem_wdata, m_regs[m_ir[17:13]]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem_arr[i] = 32'hF000_0000;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic pulse_run();
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
  endtask

  task automatic wait_retire(output int cyc, output int reqc);
    bit done;
    cyc = 0; reqc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (dmem_req === 1'b1) reqc++;
      if (retire === 1'b1) done = 1'b1;
      else if (cyc >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL retire_timeout: no retire after %0d cycles", cyc);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic step_chk(input string nm, input logic [31:0] fin, input int exp_cyc);
    int c, r;
    wait_retire(c, r);
    chk({nm, "_fin"}, finalout, fin);
    chk({nm, "_cyc"}, c, exp_cyc);
  endtask

  initial begin
    int c, r, rc;
    bit seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, rc;
    bit seen;
    clear_imem();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_pc", PC_next, 32'd0);
    chk("rst_fin", finalout, 32'd0);
    chk("rst_flags", {28'd0, retire, halted, trap, dmem_req}, 32'd0);

    // Program 1: ALU chain, memory with waits, branches, r0, halt.
    imem_arr[8'h00] = enc(4'h5, 1, 0, 0, 5);
    imem_arr[8'h04] = enc(4'h5, 2, 0, 0, -3);
    imem_arr[8'h08] = enc(4'h0, 3, 1, 2, 0);
    imem_arr[8'h0C] = enc(4'h1, 4, 2, 1, 0);
    imem_arr[8'h10] = enc(4'h7, 0, 0, 1, 16);
    imem_arr[8'h14] = enc(4'h6, 5, 0, 0, 16);
    imem_arr[8'h18] = enc(4'h0, 6, 5, 0, 0);
    imem_arr[8'h1C] = enc(4'h5, 7, 0, 0, 1);
    imem_arr[8'h20] = enc(4'h8, 0, 0, 0, 8);
    imem_arr[8'h24] = enc(4'h5, 7, 0, 0, 99);
    imem_arr[8'h28] = enc(4'h9, 0, 0, 0, 8);
    imem_arr[8'h2C] = enc(4'h5, 0, 0, 0, 7);
    imem_arr[8'h30] = enc(4'h0, 8, 0, 0, 0);
    imem_arr[8'h34] = enc(4'hF, 0, 0, 0, 0);
    ack_wait = 3;
    pulse_run();
    step_chk("addi_r1", 32'd5, 4);
    step_chk("addi_r2", 32'hFFFF_FFFD, 4);
    step_chk("add_r3", 32'd2, 4);
    step_chk("sub_r4", 32'hFFFF_FFF8, 4);
    wait_retire(c, r);
    chk("sw_cyc", c, 7);
    chk("sw_req_cycles", r, 4);
    chk("sw_ram", ram[8'h10], 32'd5);
    wait_retire(c, r);
    chk("lw_cyc", c, 8);
    chk("lw_req_cycles", r, 4);
    chk("lw_fin", finalout, 32'd5);
    step_chk("add_r6", 32'd5, 4);
    step_chk("addi_r7", 32'd1, 4);
    wait_retire(c, r);
    chk("beq_cyc", c, 3);
    chk("beq_pc", PC_next, 32'h28);
    wait_retire(c, r);
    chk("bne_cyc", c, 3);
    chk("bne_pc", PC_next, 32'h2C);
    step_chk("addi_r0", 32'd7, 4);
    step_chk("add_r0r0", 32'd0, 4);
    wait_retire(c, r);
    chk("halt_cyc", c, 3);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", PC_next, 32'h34);
    run = 1'b1; stray_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1 run = 1'b0; stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("halt_hold_pc", PC_next, 32'h34);
    chk("halt_hold", {31'd0, halted}, 32'd1);

    // Program 2: reset while a store is waiting for its ack.
    do_reset();
    clear_imem();
    imem_arr[8'h00] = enc(4'h5, 1, 0, 0, 9);
    imem_arr[8'h04] = enc(4'h7, 0, 0, 1, 32);
    ack_wait = 50;
    pulse_run();
    step_chk("addi_r1_9", 32'd9, 4);
    seen = 1'b0; rc = 0;
    while (!seen && rc < 10) begin
      @(negedge clk); rc++;
      if (dmem_req === 1'b1) seen = 1'b1;
    end
    chk("mem_req_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; stray_ack = 1'b1;
    @(negedge clk);
    chk("rstmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rstmem_pc", PC_next, 32'd0);
    chk("rstmem_fin", finalout, 32'd0);
    @(posedge clk); #1 stray_ack = 1'b0;

    // Program 3: registers cleared by that reset; JMP 0 self-loop.
    imem_arr[8'h00] = enc(4'h5, 3, 1, 0, 3);
    imem_arr[8'h04] = enc(4'hA, 0, 0, 0, 0);
    ack_wait = 0;
    pulse_run();
    step_chk("r1_cleared", 32'd3, 4);
    for (int k = 0; k < 2; k++) begin
      wait_retire(c, r);
      chk("jmp_cyc", c, 3);
      chk("jmp_pc", PC_next, 32'h4);
    end

    // Program 4: illegal opcode at pc 0x8.
    do_reset();
    clear_imem();
    imem_arr[8'h00] = enc(4'h5, 1, 0, 0, 1);
    imem_arr[8'h04] = enc(4'h5, 2, 0, 0, 2);
    imem_arr[8'h08] = enc(4'hC, 0, 0, 0, 0);
    imem_arr[8'h0C] = enc(4'hF, 0, 0, 0, 0);
    pulse_run();
    step_chk("ill_pre1", 32'd1, 4);
    step_chk("ill_pre2", 32'd2, 4);
`ifdef MCDP_ILLEGAL_TRAP_EN
    seen = 1'b0; rc = 0; r = 0;
    while (!seen && rc < 10) begin
      @(negedge clk); rc++;
      if (retire === 1'b1) r++;
      if (halted === 1'b1) seen = 1'b1;
    end
    chk("trap_halted", {31'd0, halted}, 32'd1);
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_pc", PC_next, 32'h8);
    chk("trap_no_retire", r, 0);
`else
    wait_retire(c, r);
    chk("nop_cyc", c, 3);
    chk("nop_pc", PC_next, 32'hC);
    chk("nop_trap", {31'd0, trap}, 32'd0);
    wait_retire(c, r);
    chk("nop_then_halt", {31'd0, halted}, 32'd1);
`endif
    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
